// File: rtl/req_arbiter8_if.sv
// req_arbiter8_if: requester-side bundle between the agents and the arbiter
interface req_arbiter8_if;
  logic [7:0] req;
  logic done;
  logic rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic gnt_valid;
  logic timeout;
  modport master(output req, done, rr_mode, input gnt, gnt_id, gnt_valid, timeout);
  modport slave(input req, done, rr_mode, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-way bus arbiter, fixed or round-robin priority, grant held until done/drop/timeout
module req_arbiter8 #(
  parameter int TIMEOUT = 16,
  parameter int CW = 5
) (
  input logic clk,
  input logic rst,
  req_arbiter8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, nxt;
  logic [7:0] gnt, gnt_d, rot;
  logic [2:0] gnt_id, gnt_id_d, ptr, ptr_d, sel_fix, sel_rot, sel;
  logic [CW-1:0] cnt, cnt_d;
  logic gnt_valid, gnt_valid_d, timeout, timeout_d, last, rel, win, hold;
  function automatic logic [2:0] pe8(input logic [7:0] v);
    pe8 = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) pe8 = 3'(i);
  endfunction
  // rotate so index ptr lands on bit 7; the fixed encoder then yields an offset from ptr+1
  assign rot = 8'({bus.req, bus.req} >> ({1'b0, ptr} + 4'd1));
  assign sel_fix = pe8(bus.req);
  assign sel_rot = pe8(rot) + ptr + 3'd1;
  assign last = cnt == CW'(TIMEOUT - 1);
  assign rel = bus.done | ~bus.req[gnt_id] | last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      ptr <= 3'd7;
      cnt <= '0;
    end else begin
      state <= nxt;
      gnt <= gnt_d;
      gnt_id <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
      timeout <= timeout_d;
      ptr <= ptr_d;
      cnt <= cnt_d;
    end
  end
  always_comb nxt = state == IDLE ? (|bus.req ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  always_comb begin
    sel = bus.rr_mode ? sel_rot : sel_fix;
    win = state == IDLE && |bus.req;
    hold = state == GRANT && !rel;
    gnt_d = win ? 8'd1 << sel : hold ? gnt : 8'd0;
    gnt_id_d = win ? sel : hold ? gnt_id : 3'd0;
    gnt_valid_d = win | hold;
    cnt_d = hold ? cnt + CW'(1) : '0;
    ptr_d = win && bus.rr_mode ? sel - 3'd1 : ptr;
    timeout_d = state == GRANT && last && !bus.done && bus.req[gnt_id];
  end
  assign bus.gnt = gnt;
  assign bus.gnt_id = gnt_id;
  assign bus.gnt_valid = gnt_valid;
  assign bus.timeout = timeout;
endmodule
